// File: rtl/csa8_if.sv
// Operand/result pin bundle for the carry-select adder (TinyTapeout-style pins).
interface csa8_if;
  logic        ena;
  logic [15:0] ui_in;
  logic [11:0] uo_out;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/csa8.sv
// 8-bit carry-select adder: 4-bit ripple low nibble, dual precomputed upper
// nibbles selected by the nibble carry, result registered once.
module csa8_fa (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ c;
  assign co = (x & y) | (c & (x ^ y));
endmodule

module csa8_rca4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    csa8_fa u_fa (.x(x[i]), .y(y[i]), .c(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign cout = c[4];
endmodule

module csa8 (
  input  logic    clk,
  input  logic    rst_n,
  csa8_if.slave   bus
);
  logic [7:0] a, b;
  logic [3:0] s_lo, s_hi0, s_hi1;
  logic       c4, c8_0, c8_1;
  logic [7:0] sum_d, sum_q;
  logic       cout_d, cout_q;

  assign a = bus.ui_in[7:0];
  assign b = bus.ui_in[15:8];

  csa8_rca4 u_lo  (.x(a[3:0]), .y(b[3:0]), .cin(1'b0), .s(s_lo),  .cout(c4));
  csa8_rca4 u_hi0 (.x(a[7:4]), .y(b[7:4]), .cin(1'b0), .s(s_hi0), .cout(c8_0));
  csa8_rca4 u_hi1 (.x(a[7:4]), .y(b[7:4]), .cin(1'b1), .s(s_hi1), .cout(c8_1));

  always_comb begin
    sum_d  = {c4 ? s_hi1 : s_hi0, s_lo};
    cout_d = c4 ? c8_1 : c8_0;
  end

  // rst_n is active-high despite its name (template pin kept)
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign bus.uo_out  = {3'b000, cout_q, sum_q};
  assign bus.uio_out = '0;
  assign bus.uio_oe  = '0;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.ena, bus.uio_in};
endmodule

// File: tb/tb_csa8.sv
// Scoreboard bench for csa8: driver queues a+b (or 0 under reset), monitor
// pops one expectation per edge and compares all outputs.
module tb_csa8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [11:0] exp_q[$];
  int          tag_q[$];

  csa8_if bus();
  csa8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] a, input logic [7:0] b,
                      input logic r, input int tag);
    logic [8:0] total;
    @(negedge clk);
    rst_n       = r;
    bus.ui_in   = {b, a};
    bus.ena     = 1'($urandom);
    bus.uio_in  = 8'($urandom);
    total       = {1'b0, a} + {1'b0, b};
    exp_q.push_back(r ? 12'h000 : {3'b000, total});
    tag_q.push_back(tag);
  endtask

  initial begin : monitor
    logic [11:0] e;
    int t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        if (bus.uo_out !== e) begin
          n_bad++;
          $display("FAIL uo_out tag=%0d a=%h b=%h got=%h exp=%h",
                   t, bus.ui_in[7:0], bus.ui_in[15:8], bus.uo_out, e);
        end
        n_cmp++;
        if (bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h00) begin
          n_bad++;
          $display("FAIL uio tag=%0d got out=%h oe=%h exp 00/00",
                   t, bus.uio_out, bus.uio_oe);
        end
      end
    end
  end

  initial begin : driver
    bus.ui_in  = 16'h0;
    bus.ena    = 1'b0;
    bus.uio_in = 8'h0;
    // reset for two edges with live operands
    step(8'h55, 8'h33, 1'b1, 1);
    step(8'h55, 8'h33, 1'b1, 2);
    // boundaries: nibble carry through select, wrap, max
    step(8'h0F, 8'h01, 1'b0, 3);
    step(8'hFF, 8'h01, 1'b0, 4);
    step(8'hFF, 8'hFF, 1'b0, 5);
    step(8'h00, 8'h00, 1'b0, 6);
    // back-to-back
    step(8'h12, 8'h34, 1'b0, 7);
    step(8'h80, 8'h80, 1'b0, 8);
    step(8'h7F, 8'h01, 1'b0, 9);
    // reset coincident with new operands, then release
    step(8'hAA, 8'h55, 1'b1, 10);
    step(8'hAA, 8'h55, 1'b0, 11);
    // random operands with sporadic mid-stream resets
    for (int i = 0; i < 300; i++)
      step(8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0), 12);
    // exhaustive sweep
    for (int i = 0; i < 65536; i++)
      step(i[7:0], i[15:8], 1'b0, 13);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/csa8.md
Name: csa8

Overview:
- 8-bit carry-select adder with registered outputs, packaged with a TinyTapeout-style port set (widened user I/O).
- Operands a and b arrive packed on ui_in; the 8-bit sum and carry-out leave on uo_out one clock after the operands are sampled.
- Datapath:
  - lower nibble: 4-bit ripple-carry adder;
  - upper nibble: two precomputed 4-bit ripple-carry adders, one with cin=0 and one with cin=1;
  - upper result selected by the lower-nibble carry.
- Bidirectional pins unused.

Parameters:
- none (width fixed at 8 bits; nibble split fixed at 4/4)

Ports:
- clk      input   1   system clock, rising-edge active
- rst_n    input   1   reset, synchronous, active-high (port name kept from the project template)
- ena      input   1   design-selected flag; ignored, design always operates
- ui_in    input   16  [7:0]=a, [15:8]=b (unsigned operands)
- uo_out   output  12  [7:0]=sum, [8]=cout, [11:9]=0
- uio_in   input   8   unused
- uio_out  output  8   constant 0
- uio_oe   output  8   constant 0 (all bidirectional pins inputs)

Behaviour:
- Combinational core:
  - Full adder: s = x^y^c; co = (x&y)|(c&(x^y)).
  - Lower nibble: ripple of 4 full adders on a[3:0], b[3:0], cin=0 -> s_lo[3:0], c4.
  - Upper nibble: two independent 4-full-adder ripples on a[7:4], b[7:4]:
    - one with cin=0 -> s_hi0[3:0], c8_0;
    - one with cin=1 -> s_hi1[3:0], c8_1.
  - Select: c4=0 -> {c8_0, s_hi0}; c4=1 -> {c8_1, s_hi1}.
  - Result: {cout, sum} = a + b exactly, modulo 512. No overflow flag; cout is the 9th bit.
- Register stage:
  - On each rising clk edge, sum_r <= sum and cout_r <= cout.
  - uo_out = {3'b000, cout_r, sum_r}.
- Latency: exactly 1 cycle. Operands present before edge N appear on uo_out after edge N.
- Throughput: one new addition per cycle, no handshake.
- Reset:
  - When rst_n=1 at a rising edge, sum_r <= 0 and cout_r <= 0, so uo_out = 0 after that edge.
  - Reset has priority over loading the new result.
  - Reset asserted mid-stream discards the pending result.
  - The first edge after rst_n returns to 0 loads the current a+b.
- ena, uio_in: no effect on any output.
- uio_out and uio_oe: 0 at all times, including during reset.
- uo_out[11:9]: 0 at all times.
- Boundaries:
  - 0xFF+0x01 wraps: sum=0x00, cout=1.
  - 0xFF+0xFF: sum=0xFE, cout=1.
  - Carry out of bit 3 must propagate through the select mux (0x0F+0x01=0x10).
- Before the first reset, register contents are undefined. The bench must reset first.

Test Plan:
- Assert rst_n=1 for 2 edges with a=0x55, b=0x33 -> uo_out=0x000 after the edges; uio_out=uio_oe=0x00.
- Release reset; a=0x0F, b=0x01; one edge -> sum=0x10, cout=0 (nibble carry selects the cin=1 upper adder).
- a=0xFF, b=0x01 -> next edge sum=0x00, cout=1. Then a=0xFF, b=0xFF -> sum=0xFE, cout=1. Then a=0x00, b=0x00 -> 0x000.
- Back-to-back per cycle: (0x12,0x34), (0x80,0x80), (0x7F,0x01) -> successive outputs 0x46/c0, 0x00/c1, 0x80/c0. Each appears exactly one edge after its operands.
- Assert rst_n=1 at the same edge that a=0xAA, b=0x55 is applied -> uo_out=0x000, not 0x0FF. After release, the next edge gives 0x0FF.
- Random/exhaustive sweep of all 65536 (a,b) pairs, with ena and uio_in toggled randomly -> {cout,sum}=a+b one cycle later; uo_out[11:9]=0 throughout.
